// File: rtl/systolic_ctrl_pkg.sv
// Shared types and constants for the 2x2 weight-stationary systolic array sequencer.
package systolic_ctrl_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    SWITCH,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  // Weight-load slots: bottom row first, column 2 one slot behind column 1.
  localparam logic [1:0] PH_L0 = 2'd0;
  localparam logic [1:0] PH_L1 = 2'd1;
  localparam logic [1:0] PH_L2 = 2'd2;

endpackage

// File: rtl/systolic_skew.sv
// One-stage {valid, data} delay that gives array row 2 its one-cycle skew.
module systolic_skew #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              dly_valid,
  output logic [DATA_W-1:0] dly_data
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      dly_valid <= 1'b0;
      dly_data  <= '0;
    end else begin
      dly_valid <= valid;
      dly_data  <= valid ? data : '0;
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Command sequencer for the 2x2 systolic array: weight load, switch, skewed
// row streaming and pairing of the column outputs into result beats.
module systolic_ctrl #(
  parameter int unsigned DATA_W = systolic_ctrl_pkg::DATA_W,
  parameter int unsigned ROW_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ROW_W-1:0]  cmd_rows,
  input  logic [DATA_W-1:0] cmd_w00,
  input  logic [DATA_W-1:0] cmd_w01,
  input  logic [DATA_W-1:0] cmd_w10,
  input  logic [DATA_W-1:0] cmd_w11,
  input  logic              x_valid,
  output logic              x_ready,
  input  logic [DATA_W-1:0] x_data0,
  input  logic [DATA_W-1:0] x_data1,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data0,
  output logic [DATA_W-1:0] res_data1,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sys_data_in_11,
  output logic [DATA_W-1:0] sys_data_in_21,
  output logic              sys_start_1,
  output logic              sys_start_2,
  output logic [DATA_W-1:0] sys_weight_in_11,
  output logic [DATA_W-1:0] sys_weight_in_12,
  output logic              sys_accept_w_1,
  output logic              sys_accept_w_2,
  output logic              sys_switch_in,
  input  logic [DATA_W-1:0] sys_data_out_21,
  input  logic [DATA_W-1:0] sys_data_out_22,
  input  logic              sys_valid_out_21,
  input  logic              sys_valid_out_22
);

  import systolic_ctrl_pkg::*;

  state_t            state;
  logic [1:0]        phase;
  logic [ROW_W-1:0]  n_rows;
  logic [ROW_W-1:0]  acc_cnt;
  logic [ROW_W-1:0]  res_cnt;
  logic [DATA_W-1:0] w00, w01, w10, w11;
  logic [DATA_W-1:0] hold;
  logic              accept;
  logic              pairing;

  assign cmd_ready      = (state == IDLE);
  assign x_ready        = (state == STREAM) && (acc_cnt < n_rows);
  assign accept         = x_valid && x_ready;
  assign sys_start_1    = accept;
  assign sys_data_in_11 = accept ? x_data0 : '0;
  assign pairing        = (state == STREAM) || (state == DRAIN);

  systolic_skew #(.DATA_W(DATA_W)) u_skew (
    .clk       (clk),
    .rst       (rst),
    .valid     (accept),
    .data      (x_data1),
    .dly_valid (sys_start_2),
    .dly_data  (sys_data_in_21)
  );

  // Weight/switch outputs are registered, so each slot's values are set on
  // the edge that enters that slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      phase            <= PH_L0;
      n_rows           <= '0;
      acc_cnt          <= '0;
      res_cnt          <= '0;
      w00              <= '0;
      w01              <= '0;
      w10              <= '0;
      w11              <= '0;
      hold             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      res_valid        <= 1'b0;
      res_data0        <= '0;
      res_data1        <= '0;
      sys_weight_in_11 <= '0;
      sys_weight_in_12 <= '0;
      sys_accept_w_1   <= 1'b0;
      sys_accept_w_2   <= 1'b0;
      sys_switch_in    <= 1'b0;
    end else begin
      sys_accept_w_1   <= 1'b0;
      sys_accept_w_2   <= 1'b0;
      sys_weight_in_11 <= '0;
      sys_weight_in_12 <= '0;
      sys_switch_in    <= 1'b0;
      done             <= 1'b0;
      res_valid        <= 1'b0;
      res_data0        <= '0;
      res_data1        <= '0;

      if (pairing) begin
        if (sys_valid_out_21) hold <= sys_data_out_21;
        if (sys_valid_out_22) begin
          res_valid <= 1'b1;
          res_data0 <= hold;
          res_data1 <= sys_data_out_22;
          res_cnt   <= res_cnt + ROW_W'(1);
        end
      end

      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (cmd_valid) begin
            n_rows           <= cmd_rows;
            w00              <= cmd_w00;
            w01              <= cmd_w01;
            w10              <= cmd_w10;
            w11              <= cmd_w11;
            acc_cnt          <= '0;
            res_cnt          <= '0;
            phase            <= PH_L0;
            busy             <= 1'b1;
            sys_accept_w_1   <= 1'b1;
            sys_weight_in_11 <= cmd_w10;
            state            <= LOAD_W;
          end
        end
        LOAD_W: begin
          case (phase)
            PH_L0: begin
              sys_accept_w_1   <= 1'b1;
              sys_weight_in_11 <= w00;
              sys_accept_w_2   <= 1'b1;
              sys_weight_in_12 <= w11;
              phase            <= PH_L1;
            end
            PH_L1: begin
              sys_accept_w_2   <= 1'b1;
              sys_weight_in_12 <= w01;
              phase            <= PH_L2;
            end
            default: begin
              sys_switch_in <= 1'b1;
              state         <= SWITCH;
            end
          endcase
        end
        SWITCH: begin
          if (n_rows == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            acc_cnt <= acc_cnt + ROW_W'(1);
            if (acc_cnt == n_rows - ROW_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (res_cnt == n_rows) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: behavioural 2x2 array model plus directed table and
// random commands checked against a matrix-product reference.
module tb_systolic_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [RW-1:0] cmd_rows;
  logic [DW-1:0] cmd_w00, cmd_w01, cmd_w10, cmd_w11;
  logic          x_valid, x_ready;
  logic [DW-1:0] x_data0, x_data1;
  logic          res_valid, busy, done;
  logic [DW-1:0] res_data0, res_data1;
  logic [DW-1:0] sys_data_in_11, sys_data_in_21, sys_weight_in_11, sys_weight_in_12;
  logic          sys_start_1, sys_start_2, sys_accept_w_1, sys_accept_w_2, sys_switch_in;
  logic [DW-1:0] sys_data_out_21, sys_data_out_22;
  logic          sys_valid_out_21, sys_valid_out_22;

  systolic_ctrl #(.DATA_W(DW), .ROW_W(RW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rows(cmd_rows),
    .cmd_w00(cmd_w00), .cmd_w01(cmd_w01), .cmd_w10(cmd_w10), .cmd_w11(cmd_w11),
    .x_valid(x_valid), .x_ready(x_ready), .x_data0(x_data0), .x_data1(x_data1),
    .res_valid(res_valid), .res_data0(res_data0), .res_data1(res_data1),
    .busy(busy), .done(done),
    .sys_data_in_11(sys_data_in_11), .sys_data_in_21(sys_data_in_21),
    .sys_start_1(sys_start_1), .sys_start_2(sys_start_2),
    .sys_weight_in_11(sys_weight_in_11), .sys_weight_in_12(sys_weight_in_12),
    .sys_accept_w_1(sys_accept_w_1), .sys_accept_w_2(sys_accept_w_2),
    .sys_switch_in(sys_switch_in),
    .sys_data_out_21(sys_data_out_21), .sys_data_out_22(sys_data_out_22),
    .sys_valid_out_21(sys_valid_out_21), .sys_valid_out_22(sys_valid_out_22)
  );

  // Behavioural array: shadow weights shift down each column, active weights
  // copied on switch; column 1 result two cycles after row 1 entry, column 2 one later.
  logic          m_v21, m_v22, p_v, inj_v21, inj_v22;
  logic [DW-1:0] m_d21, m_d22, p_d, inj_d;
  logic [DW-1:0] sh [2][2];
  logic [DW-1:0] aw [2][2];
  logic [DW-1:0] xq [$];

  assign sys_valid_out_21 = m_v21 | inj_v21;
  assign sys_valid_out_22 = m_v22 | inj_v22;
  assign sys_data_out_21  = inj_v21 ? inj_d : m_d21;
  assign sys_data_out_22  = inj_v22 ? inj_d : m_d22;

  always @(posedge clk) begin
    logic [DW-1:0] x0;
    if (!rst) begin
      m_v21 <= 1'b0; m_v22 <= 1'b0; p_v <= 1'b0;
      m_d21 <= '0;   m_d22 <= '0;   p_d <= '0;
      xq.delete();
    end else begin
      if (sys_accept_w_1) begin sh[1][0] <= sh[0][0]; sh[0][0] <= sys_weight_in_11; end
      if (sys_accept_w_2) begin sh[1][1] <= sh[0][1]; sh[0][1] <= sys_weight_in_12; end
      if (sys_switch_in)
        for (int r = 0; r < 2; r++) for (int k = 0; k < 2; k++) aw[r][k] <= sh[r][k];
      m_v21 <= 1'b0; m_d21 <= '0;
      m_v22 <= p_v;  m_d22 <= p_d;
      p_v   <= 1'b0; p_d   <= '0;
      if (sys_start_2) begin
        x0 = '0;
        if (xq.size() > 0) x0 = xq.pop_front();
        m_v21 <= 1'b1;
        m_d21 <= DW'(x0 * aw[0][0] + sys_data_in_21 * aw[1][0]);
        p_v   <= 1'b1;
        p_d   <= DW'(x0 * aw[0][1] + sys_data_in_21 * aw[1][1]);
      end
      if (sys_start_1) xq.push_back(sys_data_in_11);
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int done_cnt, done_cyc, last_res_cyc;
  logic          prev_s1 = 1'b0;
  logic [DW-1:0] prev_x1 = '0;
  logic [DW-1:0] res_q0 [$];
  logic [DW-1:0] res_q1 [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon();
    chk("start2_skew", 64'(sys_start_2), 64'(prev_s1));
    if (prev_s1) chk("data21_skew", 64'(sys_data_in_21), 64'(prev_x1));
    if (!sys_start_2) chk("data21_idle", 64'(sys_data_in_21), 64'd0);
    chk("start1_accept", 64'(sys_start_1), 64'(x_valid & x_ready));
    chk("data11", 64'(sys_data_in_11), sys_start_1 ? 64'(x_data0) : 64'd0);
    if (!sys_accept_w_1) chk("w11_idle", 64'(sys_weight_in_11), 64'd0);
    if (!sys_accept_w_2) chk("w12_idle", 64'(sys_weight_in_12), 64'd0);
    if (res_valid) begin
      res_q0.push_back(res_data0);
      res_q1.push_back(res_data1);
      last_res_cyc = cyc;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    prev_s1 = rst & sys_start_1;
    prev_x1 = x_data1;
  endtask

  task automatic to_neg();
    @(negedge clk);
    cyc++;
    mon();
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "/cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "/ctl_bits"}, 64'({res_valid, busy, done, x_ready, sys_start_1, sys_start_2,
        sys_accept_w_1, sys_accept_w_2, sys_switch_in}), 64'd0);
    chk({tag, "/res_data"}, 64'({res_data0, res_data1}), 64'd0);
    chk({tag, "/sys_data"}, 64'({sys_data_in_11, sys_data_in_21}), 64'd0);
    chk({tag, "/sys_wgt"}, 64'({sys_weight_in_11, sys_weight_in_12}), 64'd0);
  endtask

  task automatic run_cmd(input string tag, input logic [3:0][DW-1:0] w, input int n,
                         input logic [15:0][DW-1:0] xs0, input logic [15:0][DW-1:0] xs1,
                         input logic [15:0][1:0] gaps,
                         input logic [15:0][DW-1:0] e0, input logic [15:0][DW-1:0] e1);
    int c, i, g, budget, acc, last_acc;
    bit seen;
    res_q0.delete(); res_q1.delete();
    done_cnt = 0; done_cyc = -1; last_res_cyc = -1;
    cmd_valid = 1'b1; cmd_rows = RW'(n);
    cmd_w00 = w[0]; cmd_w01 = w[1]; cmd_w10 = w[2]; cmd_w11 = w[3];
    to_neg(); c = cyc;
    chk({tag, "/cmd_ready"}, 64'(cmd_ready), 64'd1);
    to_next();
    // junk commands while busy must be ignored
    cmd_valid = 1'($urandom_range(0, 1)); cmd_rows = RW'($urandom);
    cmd_w00 = DW'($urandom); cmd_w01 = DW'($urandom); cmd_w10 = DW'($urandom); cmd_w11 = DW'($urandom);
    to_neg();
    chk({tag, "/L0_ctl"}, 64'({sys_accept_w_1, sys_accept_w_2, sys_switch_in, busy, cmd_ready}), 64'b10010);
    chk({tag, "/L0_w11"}, 64'(sys_weight_in_11), 64'(w[2]));
    to_next();
    to_neg();
    chk({tag, "/L1_ctl"}, 64'({sys_accept_w_1, sys_accept_w_2, sys_switch_in, busy, cmd_ready}), 64'b11010);
    chk({tag, "/L1_w11"}, 64'(sys_weight_in_11), 64'(w[0]));
    chk({tag, "/L1_w12"}, 64'(sys_weight_in_12), 64'(w[3]));
    to_next();
    to_neg();
    chk({tag, "/L2_ctl"}, 64'({sys_accept_w_1, sys_accept_w_2, sys_switch_in, busy, cmd_ready}), 64'b01010);
    chk({tag, "/L2_w12"}, 64'(sys_weight_in_12), 64'(w[1]));
    to_next();
    to_neg();
    chk({tag, "/SW_ctl"}, 64'({sys_accept_w_1, sys_accept_w_2, sys_switch_in, x_ready, busy}), 64'b00101);
    to_next();

    i = 0; acc = 0; budget = 0; seen = 1'b0; last_acc = 0;
    g = (n > 0) ? int'(gaps[0]) : 0;
    while (!seen && budget < 300) begin
      if (i < n && g == 0) begin
        x_valid = 1'b1; x_data0 = xs0[i]; x_data1 = xs1[i];
      end else begin
        x_valid = (i >= n) ? 1'($urandom_range(0, 1)) : 1'b0;
        x_data0 = DW'($urandom); x_data1 = DW'($urandom);
      end
      to_neg();
      if (budget == 0) chk({tag, "/x_ready_c5"}, 64'(x_ready), 64'(n > 0));
      if (x_valid && x_ready) begin
        acc++;
        if (i == 0) chk({tag, "/first_accept"}, 64'(cyc), 64'(c + 5 + int'(gaps[0])));
        else if (i < n) chk({tag, "/row_spacing"}, 64'(cyc - last_acc), 64'(int'(gaps[i]) + 1));
        last_acc = cyc;
        if (i < n) begin i++; if (i < n) g = int'(gaps[i]); end
      end else if (i < n && g > 0) g--;
      if (done) seen = 1'b1;
      budget++;
      to_next();
    end
    x_valid = 1'b0; cmd_valid = 1'b0;
    if (!seen) chk({tag, "/done_timeout"}, 64'd0, 64'd1);
    chk({tag, "/accepts"}, 64'(acc), 64'(n));
    chk({tag, "/res_count"}, 64'(res_q0.size()), 64'(n));
    for (int k = 0; k < n && k < res_q0.size(); k++) begin
      chk({tag, "/res_data0"}, 64'(res_q0[k]), 64'(e0[k]));
      chk({tag, "/res_data1"}, 64'(res_q1[k]), 64'(e1[k]));
    end
    if (n > 0) chk({tag, "/done_after_res"}, 64'(done_cyc), 64'(last_res_cyc + 1));
    else       chk({tag, "/done_n0"}, 64'(done_cyc), 64'(c + 5));
    chk({tag, "/done_pulses"}, 64'(done_cnt), 64'd1);
    to_neg();
    chk({tag, "/post_done"}, 64'({cmd_ready, busy, done}), 64'b100);
    to_next();
  endtask

  typedef struct packed {
    logic [3:0][DW-1:0]  w;
    logic [7:0]          n;
    logic [15:0][DW-1:0] x0;
    logic [15:0][DW-1:0] x1;
    logic [15:0][1:0]    gaps;
    logic [15:0][DW-1:0] e0;
    logic [15:0][DW-1:0] e1;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [3:0][DW-1:0]  rw;
    logic [15:0][DW-1:0] rx0, rx1, re0, re1;
    logic [15:0][1:0]    rg;
    int                  rn;

    for (int k = 0; k < 5; k++) tbl[k] = '0;
    // W = {1,2,3,4}: rows (1,1),(2,0)
    tbl[0].w = {16'd4, 16'd3, 16'd2, 16'd1}; tbl[0].n = 8'd2;
    tbl[0].x0[0] = 16'd1; tbl[0].x1[0] = 16'd1; tbl[0].e0[0] = 16'd4; tbl[0].e1[0] = 16'd6;
    tbl[0].x0[1] = 16'd2; tbl[0].x1[1] = 16'd0; tbl[0].e0[1] = 16'd2; tbl[0].e1[1] = 16'd4;
    // identity, rows (5,6),(7,8), no stall
    tbl[1].w = {16'd1, 16'd0, 16'd0, 16'd1}; tbl[1].n = 8'd2;
    tbl[1].x0[0] = 16'd5; tbl[1].x1[0] = 16'd6; tbl[1].e0[0] = 16'd5; tbl[1].e1[0] = 16'd6;
    tbl[1].x0[1] = 16'd7; tbl[1].x1[1] = 16'd8; tbl[1].e0[1] = 16'd7; tbl[1].e1[1] = 16'd8;
    // same with a 2-cycle stall between rows
    tbl[2] = tbl[1]; tbl[2].gaps[1] = 2'd2;
    // N = 0
    tbl[3].w = {16'd6, 16'd7, 16'd8, 16'd9}; tbl[3].n = 8'd0;
    // diag(2,3), three rows with stalls
    tbl[4].w = {16'd3, 16'd0, 16'd0, 16'd2}; tbl[4].n = 8'd3;
    tbl[4].x0[0] = 16'd10; tbl[4].x1[0] = 16'd20; tbl[4].e0[0] = 16'd20; tbl[4].e1[0] = 16'd60;
    tbl[4].x0[1] = 16'd1;  tbl[4].x1[1] = 16'd1;  tbl[4].e0[1] = 16'd2;  tbl[4].e1[1] = 16'd3;
    tbl[4].x0[2] = 16'd0;  tbl[4].x1[2] = 16'd5;  tbl[4].e0[2] = 16'd0;  tbl[4].e1[2] = 16'd15;
    tbl[4].gaps[0] = 2'd1; tbl[4].gaps[2] = 2'd1;

    rst = 1'b0; cmd_valid = 1'b0; cmd_rows = '0;
    cmd_w00 = '0; cmd_w01 = '0; cmd_w10 = '0; cmd_w11 = '0;
    x_valid = 1'b0; x_data0 = '0; x_data1 = '0;
    inj_v21 = 1'b0; inj_v22 = 1'b0; inj_d = '0;
    done_cnt = 0; done_cyc = -1; last_res_cyc = -1;
    to_next();
    repeat (3) begin to_neg(); to_next(); end
    rst = 1'b1;
    to_neg(); chk_idle("reset"); to_next();

    // array valids in IDLE are ignored
    inj_v21 = 1'b1; inj_v22 = 1'b1; inj_d = 16'h1234;
    to_neg(); to_next();
    inj_v21 = 1'b0; inj_v22 = 1'b0;
    to_neg(); chk_idle("idle_inject"); to_next();

    for (int k = 0; k < 5; k++)
      run_cmd($sformatf("tbl%0d", k), tbl[k].w, int'(tbl[k].n), tbl[k].x0, tbl[k].x1,
              tbl[k].gaps, tbl[k].e0, tbl[k].e1);

    // reset in the middle of STREAM abandons the command
    cmd_valid = 1'b1; cmd_rows = 8'd4;
    cmd_w00 = 16'd1; cmd_w01 = 16'd0; cmd_w10 = 16'd0; cmd_w11 = 16'd1;
    to_neg(); to_next();
    cmd_valid = 1'b0;
    repeat (4) begin to_neg(); to_next(); end
    x_valid = 1'b1; x_data0 = 16'd11; x_data1 = 16'd12;
    to_neg(); chk("midrst/start1", 64'(sys_start_1), 64'd1); to_next();
    x_data0 = 16'd13; x_data1 = 16'd14;
    to_neg(); to_next();
    rst = 1'b0;
    to_neg(); to_next();
    rst = 1'b1;
    to_neg(); chk_idle("midrst"); to_next();
    x_valid = 1'b0;
    res_q0.delete(); res_q1.delete(); done_cnt = 0;
    repeat (6) begin to_neg(); to_next(); end
    chk("midrst/no_done", 64'(done_cnt), 64'd0);
    chk("midrst/no_res", 64'(res_q0.size()), 64'd0);
    run_cmd("after_rst", tbl[1].w, int'(tbl[1].n), tbl[1].x0, tbl[1].x1,
            tbl[1].gaps, tbl[1].e0, tbl[1].e1);

    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < 4; k++) rw[k] = DW'($urandom);
      rn = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
      rx0 = '0; rx1 = '0; re0 = '0; re1 = '0; rg = '0;
      for (int k = 0; k < rn; k++) begin
        rx0[k] = DW'($urandom); rx1[k] = DW'($urandom);
        rg[k]  = 2'($urandom_range(0, 2));
        re0[k] = DW'(32'(rx0[k]) * 32'(rw[0]) + 32'(rx1[k]) * 32'(rw[2]));
        re1[k] = DW'(32'(rx0[k]) * 32'(rw[1]) + 32'(rx1[k]) * 32'(rw[3]));
      end
      run_cmd($sformatf("rnd%0d", r), rw, rn, rx0, rx1, rg, re0, re1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for the 2x2 weight-stationary systolic array. Accepts a command carrying a 2x2 weight matrix W and a row count N, then:
- shifts W into the array's shadow weight registers, column-skewed;
- issues the switch pulse;
- streams N two-element input rows from a valid/ready source with row-2 skew;
- pairs the skewed column outputs into one result beat per row.

It sits between the host/DMA side and the `systolic` instance and drives every array-side input.

## Interface
Parameters:
- DATA_W, 16, element width; fixed by the array.
- ROW_W, 8, width of the row count; N max = 2^ROW_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_rows  in  ROW_W  N, number of input rows.
- cmd_w00, cmd_w01, cmd_w10, cmd_w11  in  DATA_W each  W[row][col].
- x_valid  in  1  input row offered.
- x_ready  out  1  row accepted when x_valid&x_ready.
- x_data0, x_data1  in  DATA_W each  row elements for array rows 1 and 2.
- res_valid  out  1  one-cycle result beat; no backpressure.
- res_data0, res_data1  out  DATA_W each  column 1 / column 2 results.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the last result beat has been issued.
- sys_data_in_11, sys_data_in_21  out  DATA_W each  array left inputs.
- sys_start_1, sys_start_2  out  1 each  array row valids.
- sys_weight_in_11, sys_weight_in_12  out  DATA_W each  array top weight inputs.
- sys_accept_w_1, sys_accept_w_2  out  1 each  column weight shift enables.
- sys_switch_in  out  1  shadow-to-active copy.
- sys_data_out_21, sys_data_out_22  in  DATA_W each  array bottom outputs.
- sys_valid_out_21, sys_valid_out_22  in  1 each  array output valids.

## Operation
- States: IDLE, LOAD_W, SWITCH, STREAM, DRAIN, DONE.
- IDLE: cmd_ready=1.
  - cmd_valid&cmd_ready latches W and N, then goes to LOAD_W.
- LOAD_W: 3 cycles, L0-L2. Weights are driven bottom-row first; column 2 lags column 1 by one cycle.
  - L0: accept_w_1=1, weight_in_11=W10.
  - L1: accept_w_1=1, weight_in_11=W00; accept_w_2=1, weight_in_12=W11.
  - L2: accept_w_2=1, weight_in_12=W01.
  - Then go to SWITCH.
- SWITCH: sys_switch_in=1 for exactly one cycle.
  - N=0: go to DONE.
  - Otherwise go to STREAM.
- STREAM: x_ready=1 while the accepted count is less than N.
  - On an accepted row, the same cycle drives sys_data_in_11=x_data0 and sys_start_1=1.
  - x_data1 and the accept flag are registered; on the next cycle they drive sys_data_in_21 and sys_start_2.
  - A stall (x_valid=0) yields start_1=0 for that cycle; skew is preserved.
  - After the N-th accept, go to DRAIN.
- DRAIN: wait until the result count equals N, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Result pairing:
  - Any cycle with sys_valid_out_21 captures sys_data_out_21 into a 1-entry hold register.
  - Any cycle with sys_valid_out_22 registers res_data0=hold, res_data1=sys_data_out_22, res_valid=1, and increments the result count.
  - Pairing is active in STREAM and DRAIN.
- Array outputs with no valid asserted are driven 0. Weights, data and valids are all 0 outside their slots.
- Reset:
  - rst=0 forces IDLE and clears counters and the hold register.
  - Every output is 0 except cmd_ready=1; this includes res_*, sys_*, done and busy.
  - Reset mid-operation abandons the command; no done is issued.
- Array valids arriving in IDLE are ignored and not counted.
- cmd_valid outside IDLE is ignored.
- Counters are ROW_W wide and never wrap, because count ≤ N.

## Timing
- Command accepted in cycle c:
  - LOAD_W occupies c+1..c+3.
  - SWITCH occupies c+4.
  - The first possible x_ready is c+5.
- sys_start_2 always follows sys_start_1 by exactly 1 cycle for the same row.
- res_valid is asserted the cycle after the corresponding sys_valid_out_22.
- The done cycle follows the last res_valid by 1 cycle.
- Back-to-back commands: cmd_ready returns the cycle after done.
- All outputs are registered except:
  - cmd_ready and x_ready, which are decoded from state and count;
  - sys_data_in_11 and sys_start_1, which pass x_data0 and the accept flag combinationally.

## Structure
- systolic_ctrl_pkg holds:
  - the state enum (IDLE..DONE);
  - DATA_W;
  - the LOAD_W phase constants.
- One sub-module: systolic_skew, a 1-stage {valid, data} delay register with synchronous active-low clear, used for row 2.

## Test plan
- Reset, then check idle outputs:
  - cmd_ready=1, all other outputs 0;
  - sys_valid_out_22 pulsed in IDLE → no res_valid.
- Load sequence: W={1,2,3,4}, N=2 → L0 weight_in_11=3; L1 11=1, 12=4; L2 12=2; switch pulse at c+4.
- Stream with W=identity, rows (5,6),(7,8), x_valid held high:
  - sys_start_1 at c+5 and c+6, sys_start_2 at c+6 and c+7;
  - results (5,6) then (7,8);
  - done one cycle after the second result.
- Stall: x_valid low for 2 cycles between rows → start_1 has a 2-cycle gap, row-2 skew stays 1, results unchanged.
- N=0 → LOAD_W and SWITCH only, no x_ready, done at c+5.
- rst=0 during STREAM → next cycle IDLE, all outputs 0; a new command then completes normally.
